// File: rtl/snax_cgra_tcdm_adapter_if.sv
// snax_cgra_tcdm_adapter_if
//   Bundles the CGRA data-memory channels (write address/data, read address,
//   read data) and the TCDM request/response channels for all ports.
//   Per-port fields are packed flat, port p occupying slice [p*W +: W].
// Modports:
//   slave  - the adapter's view: consumes CGRA requests and TCDM responses,
//            produces CGRA read data and TCDM requests.
//   master - the surrounding environment (CGRA array + TCDM interconnect).
interface snax_cgra_tcdm_adapter_if #(
  parameter int NumPorts      = 4,
  parameter int CgraAddrWidth = 6,
  parameter int TCDMAddrWidth = 48,
  parameter int DataWidth     = 64,
  parameter int PayloadWidth  = 16
) ();
  logic [NumPorts-1:0]                 recv_waddr_en;
  logic [NumPorts*CgraAddrWidth-1:0]   recv_waddr_msg;
  logic [NumPorts-1:0]                 recv_wdata_en;
  logic [NumPorts*PayloadWidth-1:0]    recv_wdata_payload;
  logic [NumPorts-1:0]                 recv_wdata_pred;
  logic [NumPorts-1:0]                 recv_w_rdy;
  logic [NumPorts-1:0]                 recv_raddr_en;
  logic [NumPorts*CgraAddrWidth-1:0]   recv_raddr_msg;
  logic [NumPorts-1:0]                 recv_raddr_rdy;
  logic [NumPorts-1:0]                 send_rdata_en;
  logic [NumPorts*PayloadWidth-1:0]    send_rdata_payload;
  logic [NumPorts-1:0]                 send_rdata_pred;
  logic [NumPorts-1:0]                 send_rdata_rdy;
  logic [NumPorts-1:0]                 tcdm_req_write;
  logic [NumPorts*TCDMAddrWidth-1:0]   tcdm_req_addr;
  logic [NumPorts*DataWidth-1:0]       tcdm_req_data;
  logic [NumPorts*DataWidth/8-1:0]     tcdm_req_strb;
  logic [NumPorts-1:0]                 tcdm_req_q_valid;
  logic [NumPorts-1:0]                 tcdm_req_q_ready;
  logic [NumPorts-1:0]                 tcdm_rsp_p_valid;
  logic [NumPorts*DataWidth-1:0]       tcdm_rsp_p_data;

  modport slave (
    input  recv_waddr_en, recv_waddr_msg, recv_wdata_en, recv_wdata_payload,
           recv_wdata_pred, recv_raddr_en, recv_raddr_msg, send_rdata_rdy,
           tcdm_req_q_ready, tcdm_rsp_p_valid, tcdm_rsp_p_data,
    output recv_w_rdy, recv_raddr_rdy, send_rdata_en, send_rdata_payload,
           send_rdata_pred, tcdm_req_write, tcdm_req_addr, tcdm_req_data,
           tcdm_req_strb, tcdm_req_q_valid
  );

  modport master (
    output recv_waddr_en, recv_waddr_msg, recv_wdata_en, recv_wdata_payload,
           recv_wdata_pred, recv_raddr_en, recv_raddr_msg, send_rdata_rdy,
           tcdm_req_q_ready, tcdm_rsp_p_valid, tcdm_rsp_p_data,
    input  recv_w_rdy, recv_raddr_rdy, send_rdata_en, send_rdata_payload,
           send_rdata_pred, tcdm_req_write, tcdm_req_addr, tcdm_req_data,
           tcdm_req_strb, tcdm_req_q_valid
  );
endinterface

// File: rtl/snax_cgra_tcdm_adapter.sv
// snax_cgra_tcdm_adapter
//   Per-port bridge from CGRA en/rdy memory channels to SNAX TCDM ports:
//   one-entry write and read request buffers, write-first arbitration,
//   base-relative byte addressing, credit-limited reads and a response FIFO
//   so TCDM read data is never lost while the CGRA stalls.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   enable_i        gates acceptance of new CGRA requests only
//   base_addr_i     byte base of the CGRA data memory
//   busy_o          any buffered request, read in flight or queued response
//   bus             snax_cgra_tcdm_adapter_if.slave (all per-port channels)
// Optional feature macro SNAX_CGRA_TCDM_PERF_EN adds:
//   perf_clr_i, perf_wr_cnt_o, perf_rd_cnt_o (per-port 32-bit counters of
//   accepted TCDM writes/reads).
module snax_cgra_tcdm_adapter #(
  parameter int NumPorts      = 4,
  parameter int CgraAddrWidth = 6,
  parameter int TCDMAddrWidth = 48,
  parameter int DataWidth     = 64,
  parameter int PayloadWidth  = 16,
  parameter int RspDepth      = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic [TCDMAddrWidth-1:0] base_addr_i,
  output logic                     busy_o,
`ifdef SNAX_CGRA_TCDM_PERF_EN
  input  logic                     perf_clr_i,
  output logic [NumPorts*32-1:0]   perf_wr_cnt_o,
  output logic [NumPorts*32-1:0]   perf_rd_cnt_o,
`endif
  snax_cgra_tcdm_adapter_if.slave  bus
);
  localparam int StrbWidth = DataWidth / 8;
  localparam int OffWidth  = $clog2(StrbWidth);
  localparam int CntWidth  = $clog2(RspDepth + 1);
  localparam int PtrWidth  = (RspDepth > 1) ? $clog2(RspDepth) : 1;

  function automatic logic [StrbWidth-1:0] payload_strb();
    logic [StrbWidth-1:0] m;
    m = '0;
    for (int i = 0; i < PayloadWidth / 8; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    return (int'(ptr) == RspDepth - 1) ? '0 : ptr + PtrWidth'(1);
  endfunction

  logic                     wb_valid   [NumPorts];
  logic [TCDMAddrWidth-1:0] wb_addr    [NumPorts];
  logic [PayloadWidth-1:0]  wb_payload [NumPorts];
  logic                     rb_valid   [NumPorts];
  logic [TCDMAddrWidth-1:0] rb_addr    [NumPorts];
  // cred_used counts reads from capture until their data is popped, so it
  // covers the read buffer, TCDM in-flight reads and FIFO occupancy together.
  logic [CntWidth-1:0]      cred_used  [NumPorts];
  logic [CntWidth-1:0]      inflight   [NumPorts];
  logic [CntWidth-1:0]      fifo_cnt   [NumPorts];
  logic [PtrWidth-1:0]      wr_ptr     [NumPorts];
  logic [PtrWidth-1:0]      rd_ptr     [NumPorts];
  logic [PayloadWidth-1:0]  fifo_mem   [NumPorts][RspDepth];

  logic [NumPorts-1:0] w_rdy, r_rdy, w_load, r_cap, wr_fire, rd_fire, push, pop;
  logic [TCDMAddrWidth-1:0] w_byte [NumPorts];
  logic [TCDMAddrWidth-1:0] r_byte [NumPorts];

  always_comb begin
    busy_o = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      // Readies are gated by rst_ni so they read 0 while reset is asserted.
      w_rdy[p]  = rst_ni & enable_i & ~wb_valid[p];
      r_rdy[p]  = rst_ni & enable_i & ~rb_valid[p] & (cred_used[p] < CntWidth'(RspDepth));
      // pred=0 writes are handshaken but never loaded into the buffer.
      w_load[p] = bus.recv_waddr_en[p] & bus.recv_wdata_en[p] & bus.recv_wdata_pred[p] & w_rdy[p];
      r_cap[p]  = bus.recv_raddr_en[p] & r_rdy[p];
      wr_fire[p] = wb_valid[p] & bus.tcdm_req_q_ready[p];
      rd_fire[p] = ~wb_valid[p] & rb_valid[p] & bus.tcdm_req_q_ready[p];
      // Responses with nothing outstanding (e.g. after reset) are dropped.
      push[p]   = bus.tcdm_rsp_p_valid[p] & (inflight[p] != '0);
      pop[p]    = (fifo_cnt[p] != '0) & bus.send_rdata_rdy[p];
      w_byte[p] = base_addr_i + (TCDMAddrWidth'(bus.recv_waddr_msg[p*CgraAddrWidth +: CgraAddrWidth]) << OffWidth);
      r_byte[p] = base_addr_i + (TCDMAddrWidth'(bus.recv_raddr_msg[p*CgraAddrWidth +: CgraAddrWidth]) << OffWidth);
      busy_o = busy_o | wb_valid[p] | rb_valid[p] | (inflight[p] != '0) | (fifo_cnt[p] != '0);
    end
  end

  always_comb begin
    bus.recv_w_rdy         = w_rdy;
    bus.recv_raddr_rdy     = r_rdy;
    bus.send_rdata_en      = pop;
    bus.send_rdata_pred    = pop;
    bus.send_rdata_payload = '0;
    bus.tcdm_req_write     = '0;
    bus.tcdm_req_q_valid   = '0;
    bus.tcdm_req_addr      = '0;
    bus.tcdm_req_data      = '0;
    bus.tcdm_req_strb      = '0;
    for (int p = 0; p < NumPorts; p++) begin
      bus.send_rdata_payload[p*PayloadWidth +: PayloadWidth] = fifo_mem[p][rd_ptr[p]];
      bus.tcdm_req_write[p]   = wb_valid[p];
      bus.tcdm_req_q_valid[p] = wb_valid[p] | rb_valid[p];
      bus.tcdm_req_addr[p*TCDMAddrWidth +: TCDMAddrWidth] = wb_valid[p] ? wb_addr[p] : rb_addr[p];
      bus.tcdm_req_data[p*DataWidth +: DataWidth] = wb_valid[p] ? DataWidth'(wb_payload[p]) : '0;
      bus.tcdm_req_strb[p*StrbWidth +: StrbWidth] = wb_valid[p] ? payload_strb() : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < NumPorts; p++) begin
        wb_valid[p] <= 1'b0;  wb_addr[p] <= '0;  wb_payload[p] <= '0;
        rb_valid[p] <= 1'b0;  rb_addr[p] <= '0;
        cred_used[p] <= '0;   inflight[p] <= '0;  fifo_cnt[p] <= '0;
        wr_ptr[p] <= '0;      rd_ptr[p] <= '0;
        for (int d = 0; d < RspDepth; d++) fifo_mem[p][d] <= '0;
      end
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (w_load[p]) begin
          wb_valid[p]   <= 1'b1;
          wb_addr[p]    <= w_byte[p];
          wb_payload[p] <= bus.recv_wdata_payload[p*PayloadWidth +: PayloadWidth];
        end else if (wr_fire[p]) begin
          wb_valid[p] <= 1'b0;
        end
        if (r_cap[p]) begin
          rb_valid[p] <= 1'b1;
          rb_addr[p]  <= r_byte[p];
        end else if (rd_fire[p]) begin
          rb_valid[p] <= 1'b0;
        end
        cred_used[p] <= cred_used[p] + CntWidth'(r_cap[p]) - CntWidth'(pop[p]);
        inflight[p]  <= inflight[p] + CntWidth'(rd_fire[p]) - CntWidth'(push[p]);
        fifo_cnt[p]  <= fifo_cnt[p] + CntWidth'(push[p]) - CntWidth'(pop[p]);
        if (push[p]) begin
          fifo_mem[p][wr_ptr[p]] <= bus.tcdm_rsp_p_data[p*DataWidth +: PayloadWidth];
          wr_ptr[p] <= ptr_inc(wr_ptr[p]);
        end
        if (pop[p]) rd_ptr[p] <= ptr_inc(rd_ptr[p]);
      end
    end
  end

`ifdef SNAX_CGRA_TCDM_PERF_EN
  logic [31:0] perf_wr [NumPorts];
  logic [31:0] perf_rd [NumPorts];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < NumPorts; p++) begin
        perf_wr[p] <= '0;
        perf_rd[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (perf_clr_i) begin
          perf_wr[p] <= '0;
          perf_rd[p] <= '0;
        end else begin
          perf_wr[p] <= perf_wr[p] + 32'(wr_fire[p]);
          perf_rd[p] <= perf_rd[p] + 32'(rd_fire[p]);
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      perf_wr_cnt_o[p*32 +: 32] = perf_wr[p];
      perf_rd_cnt_o[p*32 +: 32] = perf_rd[p];
    end
  end
`endif
endmodule

// File: tb/tb_snax_cgra_tcdm_adapter.sv
module tb_snax_cgra_tcdm_adapter;
  localparam int NP = 4, CAW = 6, TAW = 48, DW = 64, PW = 16, RD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic [TAW-1:0] base = '0;
  logic busy;
`ifdef SNAX_CGRA_TCDM_PERF_EN
  logic perf_clr = 1'b0;
  logic [NP*32-1:0] perf_wr, perf_rd;
`endif

  snax_cgra_tcdm_adapter_if #(.NumPorts(NP), .CgraAddrWidth(CAW), .TCDMAddrWidth(TAW),
    .DataWidth(DW), .PayloadWidth(PW)) bus ();

  snax_cgra_tcdm_adapter #(.NumPorts(NP), .CgraAddrWidth(CAW), .TCDMAddrWidth(TAW),
    .DataWidth(DW), .PayloadWidth(PW), .RspDepth(RD)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (enable),
    .base_addr_i (base),
    .busy_o      (busy),
`ifdef SNAX_CGRA_TCDM_PERF_EN
    .perf_clr_i    (perf_clr),
    .perf_wr_cnt_o (perf_wr),
    .perf_rd_cnt_o (perf_rd),
`endif
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TAW-1:0] q_addr(input int p);
    return bus.tcdm_req_addr[p*TAW +: TAW];
  endfunction
  function automatic logic [DW-1:0] q_data(input int p);
    return bus.tcdm_req_data[p*DW +: DW];
  endfunction
  function automatic logic [7:0] q_strb(input int p);
    return bus.tcdm_req_strb[p*8 +: 8];
  endfunction
  function automatic logic [PW-1:0] r_pay(input int p);
    return bus.send_rdata_payload[p*PW +: PW];
  endfunction

  task automatic clear_inputs();
    bus.recv_waddr_en = '0;  bus.recv_waddr_msg = '0;
    bus.recv_wdata_en = '0;  bus.recv_wdata_payload = '0;  bus.recv_wdata_pred = '0;
    bus.recv_raddr_en = '0;  bus.recv_raddr_msg = '0;
    bus.send_rdata_rdy = '0; bus.tcdm_req_q_ready = '1;
    bus.tcdm_rsp_p_valid = '0; bus.tcdm_rsp_p_data = '0;
  endtask

  task automatic set_write(input int p, input logic [CAW-1:0] a, input logic [PW-1:0] d,
                           input logic pred, input logic en);
    bus.recv_waddr_msg[p*CAW +: CAW] = a;
    bus.recv_wdata_payload[p*PW +: PW] = d;
    bus.recv_wdata_pred[p] = pred;
    bus.recv_waddr_en[p] = en;
    bus.recv_wdata_en[p] = en;
  endtask

  typedef struct {
    int             port;
    logic [TAW-1:0] base;
    logic [CAW-1:0] addr;
    logic [PW-1:0]  payload;
    logic [TAW-1:0] exp_addr;
    logic [DW-1:0]  exp_data;
  } wvec_t;

  wvec_t vecs[5];
  int acc;

  initial begin
    vecs[0] = '{0, 48'h1000,        6'd5,  16'hBEEF, 48'h1028,     64'h0000_0000_0000_BEEF};
    vecs[1] = '{1, 48'h0,           6'd0,  16'h0001, 48'h0,        64'h1};
    vecs[2] = '{2, 48'h2000_0000,   6'd63, 16'hFFFF, 48'h2000_01F8, 64'hFFFF};
    vecs[3] = '{3, 48'hFFFF_FFFF_FFF8, 6'd1, 16'h1357, 48'h0,      64'h1357};
    vecs[4] = '{0, 48'hFFFF_FFFF_FFF8, 6'd2, 16'h8000, 48'h8,      64'h8000};

    clear_inputs();
    enable = 1'b1;
    #12;
    // Reset state with enable high: everything must read zero.
    check("rst_q_valid", 64'(bus.tcdm_req_q_valid), 64'h0);
    check("rst_w_rdy", 64'(bus.recv_w_rdy), 64'h0);
    check("rst_raddr_rdy", 64'(bus.recv_raddr_rdy), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_send_en", 64'(bus.send_rdata_en), 64'h0);
    check("rst_addr0", 64'(q_addr(0)), 64'h0);
    check("rst_strb0", 64'(q_strb(0)), 64'h0);
    rst_n = 1'b1;
    #1;
    check("post_rst_w_rdy", 64'(bus.recv_w_rdy), 64'hF);
    check("post_rst_raddr_rdy", 64'(bus.recv_raddr_rdy), 64'hF);
    tick();

    // Table-driven single writes: address, data, strobe, ready timing.
    for (int i = 0; i < 5; i++) begin
      int p;
      p = vecs[i].port;
      base = vecs[i].base;
      set_write(p, vecs[i].addr, vecs[i].payload, 1'b1, 1'b1);
      #1 check("vec_w_rdy_pre", 64'(bus.recv_w_rdy[p]), 64'h1);
      tick();
      set_write(p, vecs[i].addr, vecs[i].payload, 1'b1, 1'b0);
      #1;
      check("vec_q_valid", 64'(bus.tcdm_req_q_valid[p]), 64'h1);
      check("vec_write", 64'(bus.tcdm_req_write[p]), 64'h1);
      check("vec_addr", 64'(q_addr(p)), 64'(vecs[i].exp_addr));
      check("vec_data", q_data(p), vecs[i].exp_data);
      check("vec_strb", 64'(q_strb(p)), 64'h03);
      check("vec_w_rdy_busy", 64'(bus.recv_w_rdy[p]), 64'h0);
      tick();
      check("vec_q_valid_done", 64'(bus.tcdm_req_q_valid[p]), 64'h0);
      check("vec_w_rdy_back", 64'(bus.recv_w_rdy[p]), 64'h1);
    end

    // Read with CGRA stall on port 1.
    base = 48'h1000;
    bus.recv_raddr_msg[1*CAW +: CAW] = 6'd3;
    bus.recv_raddr_en[1] = 1'b1;
    tick();
    bus.recv_raddr_en[1] = 1'b0;
    #1;
    check("rd_q_valid", 64'(bus.tcdm_req_q_valid[1]), 64'h1);
    check("rd_write", 64'(bus.tcdm_req_write[1]), 64'h0);
    check("rd_addr", 64'(q_addr(1)), 64'h1018);
    check("rd_raddr_rdy", 64'(bus.recv_raddr_rdy[1]), 64'h0);
    tick();
    check("rd_issued", 64'(bus.tcdm_req_q_valid[1]), 64'h0);
    tick();
    bus.tcdm_rsp_p_valid[1] = 1'b1;
    bus.tcdm_rsp_p_data[1*DW +: DW] = 64'hDEAD_BEEF_CAFE_1234;
    tick();
    bus.tcdm_rsp_p_valid[1] = 1'b0;
    repeat (5) begin
      #1;
      check("stall_no_send", 64'(bus.send_rdata_en[1]), 64'h0);
      check("stall_busy", 64'(busy), 64'h1);
      tick();
    end
    bus.send_rdata_rdy[1] = 1'b1;
    #1;
    check("send_en", 64'(bus.send_rdata_en[1]), 64'h1);
    check("send_payload", 64'(r_pay(1)), 64'h1234);
    check("send_pred", 64'(bus.send_rdata_pred[1]), 64'h1);
    tick();
    check("send_empty", 64'(bus.send_rdata_en[1]), 64'h0);
    check("send_idle_busy", 64'(busy), 64'h0);
    bus.send_rdata_rdy[1] = 1'b0;

    // Credit limit on port 2: three reads offered, two accepted.
    bus.recv_raddr_msg[2*CAW +: CAW] = 6'd7;
    bus.recv_raddr_en[2] = 1'b1;
    acc = 0;
    repeat (6) begin
      #1;
      if (bus.recv_raddr_en[2] && bus.recv_raddr_rdy[2]) acc++;
      tick();
    end
    check("credit_accepts", 64'(acc), 64'd2);
    bus.recv_raddr_en[2] = 1'b0;
    #1 check("credit_rdy_low", 64'(bus.recv_raddr_rdy[2]), 64'h0);
    bus.tcdm_rsp_p_valid[2] = 1'b1;
    bus.tcdm_rsp_p_data[2*DW +: DW] = 64'hAAAA;
    tick();
    bus.tcdm_rsp_p_data[2*DW +: DW] = 64'hBBBB;
    tick();
    bus.tcdm_rsp_p_valid[2] = 1'b0;
    #1 check("credit_full_rdy", 64'(bus.recv_raddr_rdy[2]), 64'h0);
    bus.send_rdata_rdy[2] = 1'b1;
    #1 check("fifo_first", 64'(r_pay(2)), 64'hAAAA);
    tick();
    bus.send_rdata_rdy[2] = 1'b0;
    #1 check("credit_rdy_back", 64'(bus.recv_raddr_rdy[2]), 64'h1);
    bus.send_rdata_rdy[2] = 1'b1;
    #1 check("fifo_second", 64'(r_pay(2)), 64'hBBBB);
    tick();
    bus.send_rdata_rdy[2] = 1'b0;

    // Same-cycle write and read on port 3: write goes first.
    base = 48'h1000;
    set_write(3, 6'd1, 16'h5555, 1'b1, 1'b1);
    bus.recv_raddr_msg[3*CAW +: CAW] = 6'd1;
    bus.recv_raddr_en[3] = 1'b1;
    tick();
    set_write(3, 6'd1, 16'h5555, 1'b1, 1'b0);
    bus.recv_raddr_en[3] = 1'b0;
    #1;
    check("arb_first_write", 64'(bus.tcdm_req_write[3]), 64'h1);
    check("arb_first_addr", 64'(q_addr(3)), 64'h1008);
    check("arb_first_data", q_data(3), 64'h5555);
    tick();
    check("arb_second_valid", 64'(bus.tcdm_req_q_valid[3]), 64'h1);
    check("arb_second_write", 64'(bus.tcdm_req_write[3]), 64'h0);
    check("arb_second_strb", 64'(q_strb(3)), 64'h0);
    tick();
    check("arb_done", 64'(bus.tcdm_req_q_valid[3]), 64'h0);
    bus.tcdm_rsp_p_valid[3] = 1'b1;
    bus.tcdm_rsp_p_data[3*DW +: DW] = 64'h7777;
    tick();
    bus.tcdm_rsp_p_valid[3] = 1'b0;
    bus.send_rdata_rdy[3] = 1'b1;
    #1 check("arb_rd_payload", 64'(r_pay(3)), 64'h7777);
    tick();
    bus.send_rdata_rdy[3] = 1'b0;

    // Backpressure: request held stable while q_ready is low.
    bus.tcdm_req_q_ready[3] = 1'b0;
    set_write(3, 6'd2, 16'h0A0B, 1'b1, 1'b1);
    tick();
    set_write(3, 6'd2, 16'h0A0B, 1'b1, 1'b0);
    repeat (3) begin
      #1;
      check("bp_valid", 64'(bus.tcdm_req_q_valid[3]), 64'h1);
      check("bp_addr", 64'(q_addr(3)), 64'h1010);
      check("bp_data", q_data(3), 64'h0A0B);
      tick();
    end
    bus.tcdm_req_q_ready[3] = 1'b1;
    tick();
    check("bp_released", 64'(bus.tcdm_req_q_valid[3]), 64'h0);

    // pred=0 write is consumed and dropped.
    set_write(0, 6'd4, 16'h4444, 1'b0, 1'b1);
    tick();
    set_write(0, 6'd4, 16'h4444, 1'b0, 1'b0);
    repeat (3) begin
      #1;
      check("pred0_no_valid", 64'(bus.tcdm_req_q_valid[0]), 64'h0);
      check("pred0_w_rdy", 64'(bus.recv_w_rdy[0]), 64'h1);
      tick();
    end

    // Reset with two reads in flight on port 1 and a stuck write on port 0.
    bus.recv_raddr_msg[1*CAW +: CAW] = 6'd9;
    repeat (2) begin
      bus.recv_raddr_en[1] = 1'b1;
      tick();
      bus.recv_raddr_en[1] = 1'b0;
      tick();
    end
    bus.tcdm_req_q_ready[0] = 1'b0;
    set_write(0, 6'd6, 16'h6666, 1'b1, 1'b1);
    tick();
    set_write(0, 6'd6, 16'h6666, 1'b1, 1'b0);
    bus.send_rdata_rdy = '1;
    #1 check("pre_rst_busy", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_q_valid", 64'(bus.tcdm_req_q_valid), 64'h0);
    check("mid_rst_busy", 64'(busy), 64'h0);
    check("mid_rst_w_rdy", 64'(bus.recv_w_rdy), 64'h0);
    check("mid_rst_raddr_rdy", 64'(bus.recv_raddr_rdy), 64'h0);
    check("mid_rst_send_en", 64'(bus.send_rdata_en), 64'h0);
    check("mid_rst_data0", q_data(0), 64'h0);
    rst_n = 1'b1;
    bus.tcdm_req_q_ready = '1;
    tick();
    bus.tcdm_rsp_p_valid[1] = 1'b1;
    bus.tcdm_rsp_p_data[1*DW +: DW] = 64'h9999;
    repeat (2) begin
      #1 check("late_rsp_ignored", 64'(bus.send_rdata_en[1]), 64'h0);
      tick();
    end
    bus.tcdm_rsp_p_valid[1] = 1'b0;
    #1;
    check("late_rsp_send", 64'(bus.send_rdata_en[1]), 64'h0);
    check("late_rsp_busy", 64'(busy), 64'h0);
    bus.send_rdata_rdy = '0;

`ifdef SNAX_CGRA_TCDM_PERF_EN
    repeat (3) begin
      set_write(0, 6'd1, 16'h1111, 1'b1, 1'b1);
      tick();
      set_write(0, 6'd1, 16'h1111, 1'b1, 1'b0);
      tick();
    end
    bus.recv_raddr_en[0] = 1'b1;
    tick();
    bus.recv_raddr_en[0] = 1'b0;
    tick();
    check("perf_wr0", 64'(perf_wr[31:0]), 64'd3);
    check("perf_rd0", 64'(perf_rd[31:0]), 64'd1);
    check("perf_wr1", 64'(perf_wr[63:32]), 64'd0);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    #1;
    check("perf_wr_clr", 64'(perf_wr[31:0]), 64'd0);
    check("perf_rd_clr", 64'(perf_rd[31:0]), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
